ga23_layer_pf: RTL and testbench

Parametrised successor tile-layer engine for the GA23 video pipeline.
- Computes the VRAM tile address and captures tile descriptors on `load`.
- Fetches tile rows from SDRAM with a full req/rdy handshake, holding `sdr_req` until `sdr_rdy` arrives rather than pulsing it.
- Decouples SDRAM latency through a descriptor queue and a row FIFO, then serialises 4bpp pixels to the layer mixer.
- Adds an optional 128-column wide mode and sticky overflow/underflow flags.

---
 rtl/ga23_layer_pf.sv | 236 +++++++++++++++++++++++
 tb/tb_ga23_layer_pf.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ga23_layer_pf.sv
// GA23 tile-layer engine: tile addressing, descriptor capture, SDRAM row
// fetch with a held req/rdy handshake, and 4bpp pixel serialisation.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   ce_pix                     pixel clock enable (capture and pixel output)
//   NL, large_tileset          flipped screen, upper tile bank select
//   control                    [0] rowscroll en, [1] rowselect en, [2] wide,
//                              [7] disable, [11:8] VRAM base
//   x_base..rowselect          scroll inputs
//   vram_addr                  VRAM word address of the current tile (comb)
//   load, attrib, index        tile descriptor capture
//   sdr_addr/sdr_req/sdr_rdy   SDRAM row fetch handshake, sdr_data row data
//   dbg_enabled                debug layer enable
//   color_out, prio_out        mixer pixel {palette, pixel} and priority
//   overflow, underflow        sticky queue error flags
module ga23_layer_pf #(
  parameter int unsigned DESC_DEPTH = 4,
  parameter int unsigned ROW_DEPTH  = 4,
  parameter bit          WIDE_EN    = 1'b1,
  parameter int unsigned SDR_AW     = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic              NL,
  input  logic              large_tileset,
  input  logic [15:0]       control,
  input  logic [9:0]        x_base,
  input  logic [9:0]        y_base,
  input  logic [9:0]        rowscroll,
  input  logic [9:0]        rowselect,
  output logic [14:0]       vram_addr,
  input  logic              load,
  input  logic [15:0]       attrib,
  input  logic [15:0]       index,
  output logic [SDR_AW-1:0] sdr_addr,
  output logic              sdr_req,
  input  logic              sdr_rdy,
  input  logic [31:0]       sdr_data,
  input  logic              dbg_enabled,
  output logic [10:0]       color_out,
  output logic              prio_out,
  output logic              overflow,
  output logic              underflow
);
  localparam int unsigned DPW = $clog2(DESC_DEPTH);
  localparam int unsigned DCW = DPW + 1;
  localparam int unsigned RPW = $clog2(ROW_DEPTH);
  localparam int unsigned RCW = RPW + 1;

  typedef struct packed {
    logic [SDR_AW-1:0] addr;
    logic [6:0]        palette;
    logic [1:0]        prio;
    logic              flip_x;
    logic [2:0]        offset;
  } desc_t;

  typedef struct packed {
    logic [31:0] data;
    logic [6:0]  palette;
    logic [1:0]  prio;
    logic        flip_x;
    logic [2:0]  offset;
  } row_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Scroll arithmetic and VRAM address (all mod 1024, sum wraps at 15 bits)
  logic       enabled, wide;
  logic [9:0] x, y;
  logic [6:0] tile_x;
  logic [5:0] tile_y;

  assign enabled = ~control[7] & dbg_enabled;
  assign wide    = WIDE_EN & control[2];
  assign x       = x_base + (control[0] ? rowscroll : 10'd0);
  assign y       = y_base + (control[1] ? rowselect : 10'd0);
  assign tile_x  = NL ? x[9:3] - (wide ? 7'd32 : 7'd0) : x[9:3] + (wide ? 7'd32 : 7'd0);
  assign tile_y  = y[8:3];

  always_comb begin
    if (wide) vram_addr = {control[11:9], 12'd0} + 15'({tile_y, tile_x, 1'b0});
    else      vram_addr = {control[11:8], 11'd0} + 15'({tile_y, tile_x[5:0], 1'b0});
  end

  // Descriptor built from the current tile inputs
  desc_t      cap_desc;
  logic [2:0] cap_row;
  logic       cap_en;

  assign cap_row = attrib[11] ? ~y[2:0] : y[2:0];
  assign cap_en  = ce_pix & load & enabled;

  always_comb begin
    cap_desc.addr    = SDR_AW'({attrib[12] & large_tileset, index, cap_row, 2'b00});
    cap_desc.palette = attrib[6:0];
    cap_desc.prio    = attrib[9] ? 2'b11 : attrib[8:7];
    cap_desc.flip_x  = attrib[10] ^ NL;
    cap_desc.offset  = x[2:0] ^ {3{NL}};
  end

  // Descriptor queue
  desc_t          desc_mem_q [DESC_DEPTH];
  logic [DPW-1:0] desc_wp_q, desc_rp_q;
  logic [DCW-1:0] desc_cnt_q;
  logic           desc_full, desc_empty, desc_push, desc_pop;
  desc_t          desc_head;
  state_t         state_q;

  assign desc_full  = (desc_cnt_q == DCW'(DESC_DEPTH));
  assign desc_empty = (desc_cnt_q == '0);
  assign desc_push  = cap_en & ~desc_full;
  assign desc_pop   = (state_q == S_WAIT) & sdr_rdy;
  assign desc_head  = desc_mem_q[desc_rp_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DESC_DEPTH; i++) desc_mem_q[i] <= '0;
      desc_wp_q  <= '0;
      desc_rp_q  <= '0;
      desc_cnt_q <= '0;
      overflow   <= 1'b0;
    end else begin
      if (desc_push) begin
        desc_mem_q[desc_wp_q] <= cap_desc;
        desc_wp_q             <= desc_wp_q + DPW'(1);
      end
      if (desc_pop) desc_rp_q <= desc_rp_q + DPW'(1);
      desc_cnt_q <= desc_cnt_q + DCW'(desc_push) - DCW'(desc_pop);
      if (cap_en & desc_full) overflow <= 1'b1;
    end
  end

  // Row FIFO; a fetch only starts with space free, so a push never drops
  row_t           row_mem_q [ROW_DEPTH];
  logic [RPW-1:0] row_wp_q, row_rp_q;
  logic [RCW-1:0] row_cnt_q;
  logic           row_full, row_empty, row_push, row_pop, pc_wrap;
  logic [2:0]     pc_q;
  row_t           row_in;

  assign row_full  = (row_cnt_q == RCW'(ROW_DEPTH));
  assign row_empty = (row_cnt_q == '0);
  assign row_push  = desc_pop;
  assign pc_wrap   = ce_pix & (pc_q == 3'd7);
  assign row_pop   = pc_wrap & ~row_empty;

  always_comb begin
    row_in.data    = sdr_data;
    row_in.palette = desc_head.palette;
    row_in.prio    = desc_head.prio;
    row_in.flip_x  = desc_head.flip_x;
    row_in.offset  = desc_head.offset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ROW_DEPTH; i++) row_mem_q[i] <= '0;
      row_wp_q  <= '0;
      row_rp_q  <= '0;
      row_cnt_q <= '0;
    end else begin
      if (row_push) begin
        row_mem_q[row_wp_q] <= row_in;
        row_wp_q            <= row_wp_q + RPW'(1);
      end
      if (row_pop) row_rp_q <= row_rp_q + RPW'(1);
      row_cnt_q <= row_cnt_q + RCW'(row_push) - RCW'(row_pop);
    end
  end

  // Fetch FSM: request held with a stable address until rdy
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sdr_req  <= 1'b0;
      sdr_addr <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!desc_empty && !row_full) begin
            sdr_addr <= desc_head.addr;
            sdr_req  <= 1'b1;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sdr_rdy) begin
            sdr_req <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Pixel counter and active row; an empty pop yields a transparent row
  row_t act_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= '0;
      act_q     <= '0;
      underflow <= 1'b0;
    end else if (ce_pix) begin
      pc_q <= pc_q + 3'd1;
      if (pc_wrap) begin
        if (row_empty) begin
          act_q     <= '0;
          underflow <= 1'b1;
        end else begin
          act_q <= row_mem_q[row_rp_q];
        end
      end
    end
  end

  // Pixel select: column rotated by offset, bit order reversed unless flipped
  logic [2:0] pix_col, pix_bit;
  logic [3:0] pixel;

  always_comb begin
    pix_col = pc_q + act_q.offset;
    pix_bit = act_q.flip_x ? pix_col : 3'd7 - pix_col;
    pixel   = '0;
    for (int k = 0; k < 4; k++) pixel[k] = act_q.data[{k[1:0], pix_bit}];
  end

  assign color_out = enabled ? {act_q.palette, pixel} : 11'd0;
  assign prio_out  = enabled & ((act_q.prio[0] & pixel[3]) | (act_q.prio[1] & (|pixel)));

  logic unused_bits;
  assign unused_bits = ^{attrib[15:13], control[15:12], control[6:3], y[9]};
endmodule

// File: tb/tb_ga23_layer_pf.sv
// Self-checking bench for ga23_layer_pf: queue-level reference model compared
// every cycle, plus directed scenarios with literal expected values.
module tb_ga23_layer_pf;
  localparam int M_DD = 2;
  localparam int M_RD = 4;

  logic        clk, reset, ce_pix, NL, large_tileset, load, sdr_rdy, dbg_enabled;
  logic [15:0] control, attrib, index;
  logic [9:0]  x_base, y_base, rowscroll, rowselect;
  logic [31:0] sdr_data;
  logic [14:0] vram_addr, nw_vram_addr;
  logic [21:0] sdr_addr, nw_sdr_addr;
  logic        sdr_req, nw_sdr_req, prio_out, nw_prio_out;
  logic [10:0] color_out, nw_color_out;
  logic        overflow, underflow, nw_overflow, nw_underflow;

  ga23_layer_pf #(.DESC_DEPTH(2), .ROW_DEPTH(4), .WIDE_EN(1'b1), .SDR_AW(22)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .NL(NL), .large_tileset(large_tileset),
    .control(control), .x_base(x_base), .y_base(y_base), .rowscroll(rowscroll),
    .rowselect(rowselect), .vram_addr(vram_addr), .load(load), .attrib(attrib),
    .index(index), .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_rdy(sdr_rdy),
    .sdr_data(sdr_data), .dbg_enabled(dbg_enabled), .color_out(color_out),
    .prio_out(prio_out), .overflow(overflow), .underflow(underflow));

  ga23_layer_pf #(.DESC_DEPTH(2), .ROW_DEPTH(4), .WIDE_EN(1'b0), .SDR_AW(22)) u_nw (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .NL(NL), .large_tileset(large_tileset),
    .control(control), .x_base(x_base), .y_base(y_base), .rowscroll(rowscroll),
    .rowselect(rowselect), .vram_addr(nw_vram_addr), .load(load), .attrib(attrib),
    .index(index), .sdr_addr(nw_sdr_addr), .sdr_req(nw_sdr_req), .sdr_rdy(sdr_rdy),
    .sdr_data(sdr_data), .dbg_enabled(dbg_enabled), .color_out(nw_color_out),
    .prio_out(nw_prio_out), .overflow(nw_overflow), .underflow(nw_underflow));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [21:0] addr; logic [6:0] pal; logic [1:0] prio; logic flip; logic [2:0] off;
  } md_t;
  typedef struct packed {
    logic [31:0] data; logic [6:0] pal; logic [1:0] prio; logic flip; logic [2:0] off;
  } mr_t;

  md_t         m_dq[$];
  mr_t         m_rq[$];
  bit          m_busy, m_ovf, m_unf, m_live;
  logic [21:0] m_addr;
  int          m_pc;
  mr_t         m_act;

  function automatic int m_x();
    return (int'(x_base) + (control[0] ? int'(rowscroll) : 0)) % 1024;
  endfunction
  function automatic int m_y();
    return (int'(y_base) + (control[1] ? int'(rowselect) : 0)) % 1024;
  endfunction
  function automatic bit m_en();
    return !control[7] && dbg_enabled;
  endfunction

  function automatic logic [14:0] m_vram(input bit wide_en);
    int tx, ty, w, v;
    w  = (wide_en && control[2]) ? 1 : 0;
    tx = NL ? (m_x() / 8 - 32 * w + 128) % 128 : (m_x() / 8 + 32 * w) % 128;
    ty = (m_y() / 8) % 64;
    if (w == 1) v = int'(control[11:9]) * 4096 + ty * 256 + tx * 2;
    else        v = int'(control[11:8]) * 2048 + ty * 128 + (tx % 64) * 2;
    return 15'(v % 32768);
  endfunction

  function automatic md_t m_desc();
    md_t d;
    int r;
    r      = attrib[11] ? 7 - (m_y() % 8) : m_y() % 8;
    d.addr = 22'(((attrib[12] && large_tileset) ? (1 << 21) : 0) + int'(index) * 32 + r * 4);
    d.pal  = attrib[6:0];
    d.prio = attrib[9] ? 2'd3 : attrib[8:7];
    d.flip = attrib[10] ^ NL;
    d.off  = 3'(NL ? 7 - (m_x() % 8) : m_x() % 8);
    return d;
  endfunction

  function automatic logic [3:0] m_pix();
    int p, b;
    logic [3:0] px;
    p = (m_pc + int'(m_act.off)) % 8;
    b = m_act.flip ? p : 7 - p;
    for (int k = 0; k < 4; k++) px[k] = m_act.data[8 * k + b];
    return px;
  endfunction

  function automatic logic [10:0] m_color();
    return m_en() ? {m_act.pal, m_pix()} : 11'd0;
  endfunction
  function automatic logic m_prio();
    logic [3:0] px;
    px = m_pix();
    return m_en() && ((m_act.prio[0] && px[3]) || (m_act.prio[1] && px != 4'd0));
  endfunction

  always @(posedge clk) begin : model
    int  dq_n, rq_n;
    bit  done, start, cap;
    mr_t r;
    if (reset) begin
      m_dq.delete(); m_rq.delete();
      m_busy = 0; m_ovf = 0; m_unf = 0; m_live = 0;
      m_addr = '0; m_pc = 0; m_act = '0;
    end else begin
      dq_n  = m_dq.size();
      rq_n  = m_rq.size();
      done  = m_busy && sdr_rdy;
      start = !m_busy && dq_n > 0 && rq_n < M_RD;
      cap   = ce_pix && load && m_en();
      if (ce_pix && m_pc == 7) begin
        if (rq_n > 0) begin m_act = m_rq.pop_front(); m_live = 1; end
        else begin m_act = '0; m_unf = 1; m_live = 0; end
      end
      if (done) begin
        r = {sdr_data, m_dq[0].pal, m_dq[0].prio, m_dq[0].flip, m_dq[0].off};
        m_rq.push_back(r);
        void'(m_dq.pop_front());
        m_busy = 0;
      end
      if (start) begin m_busy = 1; m_addr = m_dq[0].addr; end
      if (cap) begin
        if (dq_n >= M_DD) m_ovf = 1;
        else m_dq.push_back(m_desc());
      end
      if (ce_pix) m_pc = (m_pc + 1) % 8;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("sdr_req", sdr_req, m_busy);
      chk("sdr_addr", sdr_addr, m_addr);
      chk("vram_addr", vram_addr, m_vram(1'b1));
      chk("color_out", color_out, m_color());
      chk("prio_out", prio_out, m_prio());
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_unf);
      chk("nw_vram_addr", nw_vram_addr, m_vram(1'b0));
      chk("nw_color_out", nw_color_out, m_color());
      chk("nw_prio_out", nw_prio_out, m_prio());
      chk("nw_sdr_req", nw_sdr_req, m_busy);
      chk("nw_sdr_addr", nw_sdr_addr, m_addr);
      chk("nw_overflow", nw_overflow, m_ovf);
      chk("nw_underflow", nw_underflow, m_unf);
    end
  end

  // ---------------- directed stimulus ----------------
  logic [10:0] grp_c [8];
  logic        grp_p [8];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; tick(1); reset = 0;
  endtask

  task automatic fetch(input logic [15:0] idx, input logic [15:0] att, input logic [31:0] d);
    index = idx; attrib = att; load = 1; tick(1); load = 0;
    tick(1);
    sdr_data = d; sdr_rdy = 1; tick(1); sdr_rdy = 0;
  endtask

  // Align to the start of the next live row and sample its 8 pixels
  task automatic get_group(input string name);
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_live && m_pc == 0) found = 1;
      else tick(1);
    end
    if (!found) chk({name, " group timeout"}, 0, 1);
    for (int j = 0; j < 8; j++) begin
      grp_c[j] = color_out; grp_p[j] = prio_out; tick(1);
    end
  endtask

  initial begin
    int nf;
    logic [21:0] fa [4];
    reset = 1; ce_pix = 1; NL = 0; large_tileset = 0; control = '0;
    x_base = '0; y_base = '0; rowscroll = '0; rowselect = '0;
    load = 0; attrib = '0; index = '0; sdr_rdy = 0; sdr_data = '0; dbg_enabled = 1;
    tick(2); reset = 0; started = 1;

    chk("rst sdr_req", sdr_req, 0);
    chk("rst color", color_out, 0);
    chk("rst overflow", overflow, 0);
    chk("rst underflow", underflow, 0);

    // Reset while waiting; late rdy ignored
    index = 16'h0010; attrib = 16'h0003; load = 1; tick(1); load = 0;
    chk("A req before", sdr_req, 0);
    tick(1);
    chk("A req latency", sdr_req, 1);
    tick(2);
    reset = 1; tick(1); reset = 0;
    chk("A req after reset", sdr_req, 0);
    tick(2); sdr_data = 32'hFFFF_FFFF; sdr_rdy = 1; tick(1); sdr_rdy = 0;
    tick(1);
    chk("A req stays low", sdr_req, 0);
    tick(16);
    chk("A no row color", color_out, 0);

    // Single load, delayed rdy
    do_reset();
    index = 16'h0123; attrib = 16'h0005; load = 1; tick(1); load = 0;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      chk("B req held", sdr_req, 1);
      chk("B addr", sdr_addr, 22'h002460);
      tick(1);
    end
    sdr_data = 32'h0000_00FF; sdr_rdy = 1; tick(1); sdr_rdy = 0;
    chk("B req drop", sdr_req, 0);
    get_group("B");
    for (int j = 0; j < 8; j++) begin
      chk("B color", grp_c[j], 11'h051);
      chk("B prio", grp_p[j], 0);
    end

    // flip_x via attrib[10]
    do_reset();
    fetch(16'h0001, 16'h0405, 32'h0000_0080);
    get_group("C1");
    chk("C1 first", grp_c[0], 11'h050);
    chk("C1 last", grp_c[7], 11'h051);

    // NL cancels flip; x=7 makes offset 0; upper tile bank
    do_reset();
    NL = 1; x_base = 10'd7; large_tileset = 1;
    index = 16'h0001; attrib = 16'h1405; load = 1; tick(1); load = 0;
    tick(1);
    chk("C2 addr", sdr_addr, 22'h200020);
    sdr_data = 32'h0000_0080; sdr_rdy = 1; tick(1); sdr_rdy = 0;
    get_group("C2");
    chk("C2 first", grp_c[0], 11'h051);
    chk("C2 last", grp_c[7], 11'h050);
    NL = 0; x_base = '0; large_tileset = 0;

    // Priority forced by attrib[9], y-flipped row
    do_reset();
    y_base = 10'd3;
    index = 16'h0002; attrib = 16'h0A05; load = 1; tick(1); load = 0;
    tick(1);
    chk("D addr", sdr_addr, 22'h000050);
    sdr_data = 32'h8000_0080; sdr_rdy = 1; tick(1); sdr_rdy = 0;
    get_group("D");
    chk("D color0", grp_c[0], 11'h059);
    chk("D prio0", grp_p[0], 1);
    chk("D color1", grp_c[1], 11'h050);
    chk("D prio1", grp_p[1], 0);
    y_base = '0;

    // Wide mode addressing
    control = 16'h0104; x_base = 10'd8; #1;
    chk("E wide", vram_addr, 15'h0042);
    chk("E narrow", nw_vram_addr, 15'h0802);
    NL = 1; #1;
    chk("E wide NL", vram_addr, 15'h00C2);
    chk("E narrow NL", nw_vram_addr, 15'h0802);
    NL = 0; control = '0; x_base = '0;

    // Descriptor overflow at depth 2
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      index = 16'(i); attrib = 16'h0001; load = 1; tick(1);
    end
    load = 0;
    chk("F overflow", overflow, 1);
    nf = 0;
    for (int i = 0; i < 30; i++) begin
      if (sdr_req) begin
        if (nf < 4) fa[nf] = sdr_addr;
        nf++;
        sdr_rdy = 1; tick(1); sdr_rdy = 0;
      end else tick(1);
    end
    chk("F fetch count", nf, 2);
    chk("F addr0", fa[0], 22'h000020);
    chk("F addr1", fa[1], 22'h000040);
    chk("F overflow sticky", overflow, 1);

    // Underflow, then disabled layer
    do_reset();
    tick(7);
    chk("G no underflow yet", underflow, 0);
    tick(1);
    chk("G underflow", underflow, 1);
    for (int j = 0; j < 8; j++) begin
      chk("G transparent", color_out, 0); tick(1);
    end
    fetch(16'h0007, 16'h0205, 32'hFFFF_FFFF);
    control = 16'h0080;
    get_group("G");
    for (int j = 0; j < 8; j++) begin
      chk("G disabled color", grp_c[j], 0);
      chk("G disabled prio", grp_p[j], 0);
    end
    control = '0;

    // Mixed traffic with gapped ce_pix, checked by the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ce_pix   = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 3) == 0);
      index    = 16'($urandom);
      attrib   = 16'($urandom);
      sdr_rdy  = ($urandom_range(0, 2) == 0);
      sdr_data = $urandom;
      NL       = ($urandom_range(0, 3) == 0);
      large_tileset = 1'($urandom_range(0, 1));
      control  = 16'($urandom) & 16'h0F07;
      if ($urandom_range(0, 7) == 0) control[7] = 1'b1;
      x_base   = 10'($urandom); y_base = 10'($urandom);
      rowscroll = 10'($urandom); rowselect = 10'($urandom);
      tick(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
